// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, NRD combinational read ports, a
// per-entry pending scoreboard and a power-up clear. REGFILE_MP_BYPASS_EN adds write-to-read forwarding.
module regfile_mp #(
    parameter int WIDTH = 32,
    parameter int AW    = 5,
    parameter int NRD   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 ready,
    output logic                 dbg_state,
    input  logic                 we0,
    input  logic                 we1,
    input  logic [AW-1:0]        waddr0,
    input  logic [AW-1:0]        waddr1,
    input  logic [WIDTH-1:0]     wdata0,
    input  logic [WIDTH-1:0]     wdata1,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*WIDTH-1:0] rdata,
    output logic [NRD-1:0]       rbusy,
    input  logic                 sb_set,
    input  logic [AW-1:0]        sb_addr
);

    localparam int DEPTH = 1 << AW;

    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;

    logic [0:0]       state;
    logic [AW-1:0]    clr_cnt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] pending;
    logic             run;

    // ready is a level, not a handshake: writes and sb_set presented while it is
    // low are dropped, and reads return zero; there is no back-pressure.
    assign run       = (state == RUN);
    assign ready     = run;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            pending <= '0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (&clr_cnt)
                state <= RUN;
        end else begin
            if (we0 && waddr0 != '0)
                pending[waddr0] <= 1'b0;
            if (we1 && waddr1 != '0)
                pending[waddr1] <= 1'b0;
            // Placed last so a same-cycle set beats the clearing write.
            if (sb_set && sb_addr != '0)
                pending[sb_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clr_cnt] <= '0;
            end else begin
                if (we0 && waddr0 != '0)
                    mem[waddr0] <= wdata0;
                // Port 1 assigned second so it wins a same-address collision.
                if (we1 && waddr1 != '0)
                    mem[waddr1] <= wdata1;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] d;
        logic             b;

        assign a = raddr[k*AW +: AW];

        always_comb begin
            d = mem[a];
            b = pending[a];
`ifdef REGFILE_MP_BYPASS_EN
            if (we1 && waddr1 == a) begin
                d = wdata1;
                b = 1'b0;
            end else if (we0 && waddr0 == a) begin
                d = wdata0;
                b = 1'b0;
            end
`endif
            if (a == '0 || !run) begin
                d = '0;
                b = 1'b0;
            end
        end

        assign rdata[k*WIDTH +: WIDTH] = d;
        assign rbusy[k]                = b;
    end

endmodule
